ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single-port RAM between two requesters (port 0, port 1), each able to read or write.
//  Round-robin arbitration, req/gnt handshake, read-data return with a valid strobe.
//  Sits between the requesting logic and the RAM's we_enb/re_enb/wr_addr/rd_addr/data_in/data_out pins.
//  One RAM access per grant; no access is ever issued to both ports in the same cycle.
// PARAMETERS
//  DATA_WIDTH  8   width of RAM data words
//  ADDR_WIDTH  4   width of RAM address (depth = 2**ADDR_WIDTH)
// PORTS
//  clk       in   1           single clock, all logic rising-edge
//  rst       in   1           synchronous reset, active-high
//  req0      in   1           port 0 access request; held until gnt0
//  we0       in   1           port 0: 1 = write, 0 = read; stable while req0
//  addr0     in   ADDR_WIDTH  port 0 address; stable while req0
//  wdata0    in   DATA_WIDTH  port 0 write data; stable while req0
//  gnt0      out  1           port 0 grant, one-cycle pulse
//  rvalid0   out  1           port 0 read data valid, one-cycle pulse
//  rdata0    out  DATA_WIDTH  port 0 read data, meaningful only with rvalid0
//  req1/we1/addr1/wdata1/gnt1/rvalid1/rdata1  same as port 0, for port 1
//  we_enb    out  1           RAM write enable
//  re_enb    out  1           RAM read enable
//  wr_addr   out  ADDR_WIDTH  RAM write address
//  rd_addr   out  ADDR_WIDTH  RAM read address
//  data_in   out  DATA_WIDTH  RAM write data
//  data_out  in   DATA_WIDTH  RAM read data, valid 1 cycle after re_enb
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0 (port 0 preferred); all outputs 0.
//  All outputs are registered.
//  FSM states:
//   IDLE : if any req, choose winner, latch its we/addr/wdata, go GRANT.
//          Winner: a lone requester wins; if both request, rr_ptr wins.
//   GRANT: gnt_w=1 for exactly this cycle; drive the RAM command for one cycle.
//          write: we_enb=1, wr_addr/data_in from latch; -> IDLE.
//          read : re_enb=1, rd_addr from latch; -> RD_WAIT.
//          rr_ptr <= ~winner.
//   RD_WAIT: capture data_out into rdata_w; rvalid_w=1 next cycle; -> IDLE.
//  Latency (from req seen in IDLE at cycle N):
//   gnt and RAM strobe at N+1; rvalid/rdata at N+3.
//  Throughput: write = 2 cycles/access, read = 3 cycles/access.
//  Fairness: under continuous contention, grants strictly alternate 0,1,0,1...
//  Requests made outside IDLE wait; they are sampled at the next IDLE.
//  A requester drops req the cycle after gnt.
//   If req is still high then, it is treated as a new request.
//  Inactive RAM address/data outputs hold their last value.
//   we_enb and re_enb are never 1 together.
//  rdata_x holds its last captured value when rvalid_x=0.
//  Reset mid-operation:
//   any state -> IDLE next cycle; pending gnt/rvalid suppressed; rr_ptr=0.
//   A read in flight is discarded; no rvalid is produced for it.
//  Addresses use full ADDR_WIDTH with no bounds check; 2**ADDR_WIDTH-1 is legal.
// TESTING
//  1 Reset: rst=1 for 2 cycles with req0=req1=1 -> all outputs 0, no gnt until the cycle after rst falls +1.
//  2 Single write/read: p0 write addr=4'h3 data=8'hA5, then p0 read addr=4'h3 ->
//    gnt0 at N+1 with we_enb=1; later rvalid0=1 with rdata0=8'hA5, 2 cycles after its gnt.
//  3 Contention: req0=req1=1 held, 6 accesses -> grant order 0,1,0,1,0,1; never both gnt high.
//  4 Cross-port data: p1 write addr=4'hF data=8'h3C, then p0 read addr=4'hF ->
//    rdata0=8'h3C; rvalid1 stays 0.
//  5 Reset in RD_WAIT: assert rst during a p1 read -> no rvalid1; next grant after reset goes to p0 if both request.
//  6 Back-to-back single requester: req1 held high, writes to addr 0..15 ->
//    gnt1 every 2nd cycle; RAM contents match when read back.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM.
// Each grant issues exactly one RAM access; read data returns with a one-cycle valid strobe.
//
// state   | meaning
// IDLE    | waiting for a request; picks the winner and issues its command
// GRANT   | grant pulse and RAM strobe are on the outputs
// RD_WAIT | RAM read data is on data_out and is captured for the winner
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  we_enb,
  output logic                  re_enb,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] data_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   rr_ptr, rr_ptr_nxt;
  logic   win_l, we_l;

  logic                  any_req, win, win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  logic                  gnt0_d, gnt1_d, rvalid0_d, rvalid1_d;
  logic                  we_enb_d, re_enb_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d, rd_addr_d;
  logic [DATA_WIDTH-1:0] data_in_d, rdata0_d, rdata1_d;

  // rr_ptr only breaks ties; a lone requester always wins
  always_comb begin
    any_req   = req0 | req1;
    win       = (req0 & req1) ? rr_ptr : req1;
    win_we    = win ? we1    : we0;
    win_addr  = win ? addr1  : addr0;
    win_wdata = win ? wdata1 : wdata0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
      win_l  <= 1'b0;
      we_l   <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      if (state == IDLE && any_req) begin
        win_l <= win;
        we_l  <= win_we;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = GRANT;
      end
      GRANT: begin
        state_nxt  = we_l ? IDLE : RD_WAIT;
        rr_ptr_nxt = ~win_l;
      end
      RD_WAIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the output registers; addresses and read data hold by default
  always_comb begin
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    we_enb_d  = 1'b0;
    re_enb_d  = 1'b0;
    wr_addr_d = wr_addr;
    rd_addr_d = rd_addr;
    data_in_d = data_in;
    rdata0_d  = rdata0;
    rdata1_d  = rdata1;
    case (state)
      IDLE: begin
        if (any_req) begin
          gnt0_d = ~win;
          gnt1_d = win;
          if (win_we) begin
            we_enb_d  = 1'b1;
            wr_addr_d = win_addr;
            data_in_d = win_wdata;
          end else begin
            re_enb_d  = 1'b1;
            rd_addr_d = win_addr;
          end
        end
      end
      RD_WAIT: begin
        if (win_l) begin
          rvalid1_d = 1'b1;
          rdata1_d  = data_out;
        end else begin
          rvalid0_d = 1'b1;
          rdata0_d  = data_out;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
      we_enb  <= 1'b0;
      re_enb  <= 1'b0;
      wr_addr <= '0;
      rd_addr <= '0;
      data_in <= '0;
    end else begin
      gnt0    <= gnt0_d;
      gnt1    <= gnt1_d;
      rvalid0 <= rvalid0_d;
      rvalid1 <= rvalid1_d;
      rdata0  <= rdata0_d;
      rdata1  <= rdata1_d;
      we_enb  <= we_enb_d;
      re_enb  <= re_enb_d;
      wr_addr <= wr_addr_d;
      rd_addr <= rd_addr_d;
      data_in <= data_in_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: a transaction-level model predicts grant order and
// read data; a negedge monitor checks every grant, RAM strobe and read return against it.
module tb_ram_port_arbiter;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;
  logic req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic we_enb, re_enb;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] data_in, data_out;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .we_enb(we_enb), .re_enb(re_enb), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .data_in(data_in), .data_out(data_out)
  );

  // Single-port RAM: read data appears the cycle after re_enb
  logic [DW-1:0] ram [16];
  always @(posedge clk) begin
    if (we_enb) ram[wr_addr] <= data_in;
    if (re_enb) data_out <= ram[rd_addr];
  end

  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } gexp_t;
  typedef struct {
    int            port;
    logic [DW-1:0] data;
  } rexp_t;

  gexp_t exp_g[$];
  rexp_t exp_r[$];
  int    due_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: memory contents, tie-break preference, outstanding requests
  logic [DW-1:0] mem_m [16];
  int            pref = 0;
  bit            pend [2];
  logic          pwe [2];
  logic [AW-1:0] paddr [2];
  logic [DW-1:0] pdata [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int p);
    if (p == 0) begin
      req0 = pend[0]; we0 = pwe[0]; addr0 = paddr[0]; wdata0 = pdata[0];
    end else begin
      req1 = pend[1]; we1 = pwe[1]; addr1 = paddr[1]; wdata1 = pdata[1];
    end
  endtask

  task automatic new_req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[p] = 1'b1; pwe[p] = we; paddr[p] = a; pdata[p] = d;
    drive(p);
  endtask

  // Predict the next winner, record expectations, wait for the grant, drop that request.
  task automatic issue(input bit track_read, output int lat);
    int    w;
    gexp_t e;
    rexp_t r;
    w = (pend[0] && pend[1]) ? pref : (pend[1] ? 1 : 0);
    e.port = w; e.we = pwe[w]; e.addr = paddr[w]; e.data = pdata[w];
    exp_g.push_back(e);
    if (pwe[w]) mem_m[paddr[w]] = pdata[w];
    else if (track_read) begin
      r.port = w; r.data = mem_m[paddr[w]];
      exp_r.push_back(r);
    end
    pref = 1 - w;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(gnt0 || gnt1) && lat < 12);
    if (!(gnt0 || gnt1)) begin
      vectors++;
      miscompares++;
      $display("FAIL grant_timeout: no grant after %0d cycles, required port %0d", lat, w);
    end
    pend[w] = 1'b0;
    drive(w);
  endtask

  task automatic check_zero();
    chk("rst_gnt",     32'({gnt1, gnt0}), 32'(0));
    chk("rst_rvalid",  32'({rvalid1, rvalid0}), 32'(0));
    chk("rst_rdata0",  32'(rdata0), 32'(0));
    chk("rst_rdata1",  32'(rdata1), 32'(0));
    chk("rst_strobes", 32'({we_enb, re_enb}), 32'(0));
    chk("rst_addrs",   32'({wr_addr, rd_addr}), 32'(0));
    chk("rst_data_in", 32'(data_in), 32'(0));
  endtask

  task automatic reset_pulse(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
      check_zero();
    end
    rst = 1'b0;
    pref = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    gexp_t e;
    rexp_t r;
    int    d;
    cyc++;
    if (cyc > 1) begin
      chk("one_gnt", 32'(gnt0 & gnt1), 32'(0));
      chk("one_strobe", 32'(we_enb & re_enb), 32'(0));
      if (gnt0 || gnt1) begin
        if (exp_g.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_gnt: actual gnt0=%0b gnt1=%0b required none", gnt0, gnt1);
        end else begin
          e = exp_g.pop_front();
          chk("gnt_port", 32'(gnt1), 32'(e.port));
          chk("gnt_we", 32'(we_enb), 32'(e.we));
          chk("gnt_re", 32'(re_enb), 32'(!e.we));
          if (e.we) begin
            chk("wr_addr", 32'(wr_addr), 32'(e.addr));
            chk("data_in", 32'(data_in), 32'(e.data));
          end else begin
            chk("rd_addr", 32'(rd_addr), 32'(e.addr));
            due_q.push_back(cyc + 2);
          end
        end
      end else begin
        chk("strobe_no_gnt", 32'(we_enb | re_enb), 32'(0));
      end
      if (rvalid0 || rvalid1) begin
        chk("rvalid_both", 32'(rvalid0 & rvalid1), 32'(0));
        if (due_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_rvalid: actual rvalid0=%0b rvalid1=%0b required none", rvalid0, rvalid1);
        end else begin
          d = due_q.pop_front();
          chk("rvalid_lat", cyc, d);
        end
        if (exp_r.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_rdata: actual rvalid0=%0b rvalid1=%0b required none", rvalid0, rvalid1);
        end else begin
          r = exp_r.pop_front();
          chk("rvalid_port", 32'(rvalid1), 32'(r.port));
          chk("rdata", 32'(rvalid1 ? rdata1 : rdata0), 32'(r.data));
        end
      end
    end
    if (rst) due_q.delete();
  end

  initial begin
    int lat;
    int first;
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;

    // Reset held with both requesting
    new_req(0, 1'b1, 4'h0, 8'h11);
    new_req(1, 1'b1, 4'h1, 8'h22);
    reset_pulse(2);
    issue(1'b1, lat);
    chk("t1_first_gnt_lat", 32'(lat), 32'(1));
    chk("t1_first_is_p0", 32'(gnt0), 32'(1));
    issue(1'b1, lat);
    chk("t1_second_gnt_lat", 32'(lat), 32'(2));

    // Single write then read on port 0
    idle(3);
    new_req(0, 1'b1, 4'h3, 8'hA5);
    issue(1'b1, lat);
    chk("t2_wr_lat", 32'(lat), 32'(1));
    chk("t2_we_enb", 32'(we_enb), 32'(1));
    new_req(0, 1'b0, 4'h3, 8'h00);
    issue(1'b1, lat);
    chk("t2_rd_lat", 32'(lat), 32'(2));
    idle(2);
    chk("t2_rvalid0", 32'(rvalid0), 32'(1));
    chk("t2_rdata0", 32'(rdata0), 32'hA5);

    // Cross-port data, top address
    new_req(1, 1'b1, 4'hF, 8'h3C);
    issue(1'b1, lat);
    new_req(0, 1'b0, 4'hF, 8'h00);
    issue(1'b1, lat);
    idle(2);
    chk("t4_rvalid0", 32'(rvalid0), 32'(1));
    chk("t4_rvalid1", 32'(rvalid1), 32'(0));
    chk("t4_rdata0", 32'(rdata0), 32'h3C);

    // Back-to-back port 1 writes over the whole array, then read back
    new_req(1, 1'b1, 4'h0, 8'($urandom_range(255)));
    issue(1'b1, lat);
    for (int i = 1; i < 16; i++) begin
      new_req(1, 1'b1, 4'(i), 8'($urandom_range(255)));
      issue(1'b1, lat);
      chk("t6_wr_spacing", 32'(lat), 32'(2));
    end
    new_req(1, 1'b0, 4'h0, 8'h00);
    issue(1'b1, lat);
    chk("t6_wr_to_rd", 32'(lat), 32'(2));
    for (int i = 1; i < 16; i++) begin
      new_req(1, 1'b0, 4'(i), 8'h00);
      issue(1'b1, lat);
      chk("t6_rd_spacing", 32'(lat), 32'(3));
    end
    idle(3);

    // Continuous contention: grants alternate
    first = pref;
    new_req(0, 1'b1, 4'($urandom_range(15)), 8'($urandom_range(255)));
    new_req(1, 1'b1, 4'($urandom_range(15)), 8'($urandom_range(255)));
    for (int k = 0; k < 6; k++) begin
      issue(1'b1, lat);
      chk("t3_order", 32'(gnt1), 32'((first + k) % 2));
      if (k > 0) chk("t3_spacing", 32'(lat), 32'(2));
      if (k < 5) begin
        for (int p = 0; p < 2; p++)
          if (!pend[p]) new_req(p, 1'b1, 4'($urandom_range(15)), 8'($urandom_range(255)));
      end
    end
    while (pend[0] || pend[1]) issue(1'b1, lat);
    idle(3);

    // Reset during RD_WAIT of a port-1 read discards it
    new_req(1, 1'b0, 4'h5, 8'h00);
    issue(1'b0, lat);
    idle(1);
    reset_pulse(1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("t5_no_rvalid1", 32'(rvalid1), 32'(0));
    end
    new_req(0, 1'b1, 4'h6, 8'($urandom_range(255)));
    new_req(1, 1'b1, 4'h7, 8'($urandom_range(255)));
    issue(1'b1, lat);
    chk("t5_p0_after_rst", 32'(gnt0), 32'(1));
    // Reset in the grant cycle must also return the tie-break to port 0
    new_req(0, 1'b1, 4'h8, 8'($urandom_range(255)));
    reset_pulse(1);
    issue(1'b1, lat);
    chk("t5b_p0_after_rst", 32'(gnt0), 32'(1));
    while (pend[0] || pend[1]) issue(1'b1, lat);
    idle(3);

    // Randomized mixed traffic
    for (int k = 0; k < 80; k++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(9) < 7)
          new_req(p, 1'($urandom_range(1)), 4'($urandom_range(15)), 8'($urandom_range(255)));
      if (!pend[0] && !pend[1])
        new_req(int'($urandom_range(1)), 1'($urandom_range(1)), 4'($urandom_range(15)), 8'($urandom_range(255)));
      issue(1'b1, lat);
    end
    while (pend[0] || pend[1]) issue(1'b1, lat);
    idle(8);

    chk("grants_outstanding", 32'(exp_g.size()), 32'(0));
    chk("reads_outstanding", 32'(exp_r.size()), 32'(0));
    chk("rvalid_outstanding", 32'(due_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
